// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit the clock, request to send, shift out
// start/data/parity/stop on device clock falls, then check the device ACK.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to twice before tx_error.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_ERR
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fe;
  logic [7:0]             data_q;
  logic [9:0]             shift_q;
  logic [3:0]             bit_cnt;
  logic [INH_W-1:0]       inh_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic                   wd_expired;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]             retry_cnt;
`endif

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign dat_s      = dat_sync[SYNC_STAGES-1];
  assign fe         = clk_prev & ~clk_s;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Pad synchronizers (idle-high lines) and previous clock for edge detect
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
      clk_prev <= clk_s;
    end
  end

  // Frame sequencer with registered line enables and status outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      data_q     <= '0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      wd_cnt     <= '0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_busy    <= 1'b0;
          if (tx_valid && tx_ready) begin
            data_q     <= tx_data;
            inh_cnt    <= '0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_cnt  <= '0;
`endif
          end else begin
            tx_ready <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_dat_oe <= 1'b1;
            state      <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end
        S_REQ: begin
          // Start bit is already on the data line; release the clock to the device
          ps2_clk_oe <= 1'b0;
          shift_q    <= {1'b1, ~^data_q, data_q};
          bit_cnt    <= '0;
          wd_cnt     <= '0;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (fe) begin
            wd_cnt     <= '0;
            ps2_dat_oe <= ~shift_q[0];
            shift_q    <= {1'b0, shift_q[9:1]};
            bit_cnt    <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) state <= S_ACK;
          end else if (wd_expired) begin
            ps2_dat_oe <= 1'b0;
            state      <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_ACK: begin
          if (fe) begin
            wd_cnt <= '0;
            state  <= dat_s ? S_ERR : S_WAIT_IDLE;
          end else if (wd_expired) begin
            state <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b0;
            state    <= S_IDLE;
          end else if (fe) begin
            wd_cnt <= '0;
          end else if (wd_expired) begin
            state <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_ERR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
          if (retry_cnt < 2'd2) begin
            retry_cnt  <= retry_cnt + 2'd1;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end else begin
            tx_error <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b0;
            state    <= S_IDLE;
          end
`else
          tx_error <= 1'b1;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b0;
          state    <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH      = 200;
  localparam int TO       = 3000;
  localparam int H        = 20;
  localparam int WAIT_LIM = 20000;
`ifdef PS2_TX_RETRY_EN
  localparam int NACK_ATTEMPTS = 3;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;
  logic       clk_line, dat_line;

  assign clk_line = ~ps2_clk_oe & ~dev_clk_low;
  assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it: {stop, odd parity, data, start}
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Monitor: pulse counts, pulse-cycle status, inhibit/request run lengths
  int   cyc = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, last_gap = 0;
  int   inh_run = 0, req_run = 0;
  int   inh_q[$];
  int   req_q[$];
  logic busy_d = 1'b0, pulse_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_error) err_cnt++;
    if (tx_busy && !busy_d) last_gap = cyc - done_cyc;
    if (tx_done || tx_error) begin
      chk("busy_low_at_pulse", 32'(tx_busy), 0);
      chk("ready_low_at_pulse", 32'(tx_ready), 0);
      chk("done_err_exclusive", 32'(tx_done & tx_error), 0);
    end
    if (pulse_d) chk("ready_after_pulse", 32'(tx_ready), 1);
    if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
    else if (inh_run > 0) begin
      inh_q.push_back(inh_run);
      inh_run = 0;
    end
    if (ps2_clk_oe && ps2_dat_oe) req_run++;
    else if (req_run > 0) begin
      req_q.push_back(req_run);
      req_run = 0;
    end
    busy_d  = tx_busy;
    pulse_d = tx_done | tx_error;
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < WAIT_LIM) begin
      @(negedge clk);
      n++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int n;
    n = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && n < WAIT_LIM) begin
      @(negedge clk);
      n++;
    end
    ok = (n < WAIT_LIM);
  endtask

  // Device: wait for request-to-send, then clock npulse falls, sampling on rises
  task automatic dev_frame(input bit ack, input int npulse, output logic [10:0] fr, output bit ok);
    fr = '0;
    wait_release(ok);
    if (ok) begin
      repeat (6) @(negedge clk);
      fr[0] = dat_line;
      for (int k = 1; k <= npulse; k++) begin
        if (k == 11) dev_dat_low = ack;
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k <= 10) fr[k] = dat_line;
        repeat (H) @(negedge clk);
      end
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input logic [7:0] d, input bit ack, input int exp_done,
                         input int exp_err, input string tag);
    int d0, e0, att, nq;
    logic [10:0] fr;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    inh_q.delete();
    req_q.delete();
    att = ack ? 1 : NACK_ATTEMPTS;
    fork
      send(d);
      for (int a = 0; a < att; a++) begin
        dev_frame(ack, 11, fr, ok);
        chk({tag, "_request"}, 32'(ok), 1);
        chk({tag, "_frame"}, 32'(fr), 32'(ref_frame(d)));
      end
    join
    wait_pulse(d0, e0);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({tag, "_err_cnt"}, 32'(err_cnt - e0), 32'(exp_err));
    chk({tag, "_ready"}, 32'(tx_ready), 1);
    chk({tag, "_lines_free"}, 32'({ps2_clk_oe, ps2_dat_oe, tx_busy}), 0);
    nq = inh_q.size();
    chk({tag, "_inhibit_count"}, 32'(nq), 32'(att));
    for (int i = 0; i < nq; i++) chk({tag, "_inhibit_len"}, 32'(inh_q[i]), INH);
    chk({tag, "_req_count"}, 32'(req_q.size()), 32'(att));
    if (req_q.size() > 0) chk({tag, "_req_len"}, 32'(req_q[0]), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [10:0] fr, fr2;
    bit          ok, ok2;
    int          d0, e0, n;
    logic [7:0]  rd;

    vecs[0] = '{8'hED, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b0, 0, 1};
    vecs[2] = '{8'h02, 1'b1, 1, 0};
    vecs[3] = '{8'hF3, 1'b1, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 0, 1};

    resetn      = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(tx_ready), 1);
    chk("reset_busy", 32'(tx_busy), 0);
    chk("reset_pulses", 32'({tx_done, tx_error}), 0);
    chk("reset_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 6; i++)
      run_vec(vecs[i].data, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_err, "vec");

    // Random bytes, device ACKs
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      run_vec(rd, 1'b1, 1, 0, "rand");
    end

    // Device never clocks: watchdog
    e0 = err_cnt;
    d0 = done_cnt;
    fork
      send(8'h00);
      for (int a = 0; a < NACK_ATTEMPTS; a++) begin
        wait_release(ok);
        chk("timeout_request", 32'(ok), 1);
        n = 0;
        while (!tx_error && !ps2_clk_oe && n < TO + 100) begin
          @(negedge clk);
          n++;
        end
        chk("timeout_window", 32'(n >= TO && n <= TO + 2), 1);
      end
    join
    chk("timeout_error", 32'(tx_error), 1);
    chk("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    @(negedge clk);
    chk("timeout_ready", 32'(tx_ready), 1);
    chk("timeout_counts", 32'({err_cnt - e0, done_cnt - d0}), 32'({32'(1), 32'(0)}));

    // tx_valid pulse during SEND is ignored
    d0 = done_cnt;
    fork
      send(8'hF3);
      dev_frame(1'b1, 11, fr, ok);
      begin
        wait_release(ok2);
        repeat (60) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chk("ignore_frame", 32'(fr), 32'(ref_frame(8'hF3)));
    chk("ignore_parity", 32'(fr[9]), 1);
    repeat (INH + 50) @(negedge clk);
    chk("ignore_done_cnt", 32'(done_cnt - d0), 1);
    chk("ignore_no_new_frame", 32'({tx_busy, ps2_clk_oe}), 0);

    // Asynchronous reset mid-frame (after bit 4 is presented)
    fork
      send(8'hED);
      dev_frame(1'b1, 5, fr, ok);
    join
    chk("mid_bits", 32'(fr[5:0]), 32'(6'b011010));
    chk("mid_dat_oe", 32'(ps2_dat_oe), 1);
    chk("mid_busy", 32'(tx_busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("async_rst_busy", 32'(tx_busy), 0);
    chk("async_rst_ready", 32'(tx_ready), 1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(8'hED, 1'b1, 1, 0, "post_reset");

    // Back-to-back with tx_valid held high
    d0       = done_cnt;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    fork
      begin
        dev_frame(1'b1, 11, fr, ok);
        chk("b2b_frame0", 32'(fr), 32'(ref_frame(8'hED)));
        dev_frame(1'b1, 11, fr2, ok2);
        chk("b2b_frame1", 32'(fr2), 32'(ref_frame(8'h02)));
        chk("b2b_parity1", 32'(fr2[9]), 0);
      end
      begin
        n = 0;
        while (!tx_busy && n < WAIT_LIM) begin
          @(negedge clk);
          n++;
        end
        tx_data = 8'h02;
        n = 0;
        while (done_cnt == d0 && n < WAIT_LIM) begin
          @(negedge clk);
          n++;
        end
        n = 0;
        while (!tx_busy && n < 50) begin
          @(negedge clk);
          n++;
        end
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_accept_gap", 32'(last_gap), 2);
      end
    join
    wait_pulse(d0 + 1, err_cnt);
    chk("b2b_done_cnt", 32'(done_cnt - d0), 2);
    chk("b2b_idle", 32'({tx_busy, tx_ready}), 32'(2'b01));

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
